// File: rtl/uar_tx.sv
// uar_tx: parallel-to-serial 8N1 UART packet transmitter, LSB first.
// Sends a DATA_WIDTH-bit word as ceil(DATA_WIDTH/8) back-to-back characters.
//
// Ports:
//   clk_in   in   system clock, rising edge
//   rst_in   in   asynchronous active-high reset
//   data_in  in   packet payload, sampled only in the accept cycle
//   send_in  in   request strobe, honoured only while idle
//   tx       out  serial line, idle high, registered
//   busy     out  high from the cycle after accept until packet end
//   done     out  one-cycle pulse when the packet completes
module uar_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 162
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  send_in,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int NUM_BYTES = (DATA_WIDTH + 7) / 8;
  localparam int PW        = 8 * NUM_BYTES;
  localparam int BW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int YW =
    (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [YW-1:0] BYTE_LAST = YW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state_q;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic [YW-1:0]   byte_q;
  logic [PW-1:0]   shreg_q;
  logic            tx_q;
  logic            busy_q;
  logic            done_q;

  logic            bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

  // tx is always loaded with the value the next state will present,
  // so the line is a pure flop output with no decode glitches.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          baud_q <= '0;
          if (send_in) begin
            // Zero-extension pads the last character above the payload.
            shreg_q <= PW'(data_in);
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shreg_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q  <= '0;
            // Eight shifts per character leave the next byte in [7:0].
            shreg_q <= shreg_q >> 1;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
              tx_q  <= shreg_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (byte_q != BYTE_LAST) begin
              byte_q  <= byte_q + 1'b1;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          baud_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uar_tx.sv
// tb_uar_tx: scoreboard bench for uar_tx with a UART decoder on tx.
// Stimulus pushes expected packets; a monitor decodes and compares.
module tb_uar_tx;

  localparam int CPB = 4;
  localparam int DW  = 162;
  localparam int NB  = 21;
  localparam int PKT = 10 * NB * CPB;

  typedef struct {
    logic [DW-1:0] data;
    int            done_cyc;
  } exp_t;

  logic          clk_in;
  logic          rst_in;
  logic [DW-1:0] data_in;
  logic          send_in;
  logic          tx;
  logic          busy;
  logic          done;

  int   n_cmp;
  int   n_fail;
  int   cyc;
  exp_t exp_q[$];

  uar_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .data_in(data_in),
    .send_in(send_in),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial cyc = 0;
  always_ff @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [167:0] got,
                     input logic [167:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               name, got, want, cyc);
    end
  endtask

  task automatic wait_neg(input int n);
    while (1) begin
      @(negedge clk_in);
      if (cyc >= n) break;
    end
  endtask

  // Returns a such that cycle k of the packet is cyc == a+k.
  task automatic send(input logic [DW-1:0] d, output int a);
    exp_t e;
    @(posedge clk_in);
    #1;
    data_in = d;
    send_in = 1'b1;
    @(posedge clk_in);
    #1;
    send_in = 1'b0;
    a = cyc - 1;
    e.data = d;
    e.done_cyc = a + PKT + 1;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk_in);
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: pending %0d want 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: reference decoder plus done/busy scoreboard.
  initial begin
    int            pos;
    bit            in_char;
    logic [7:0]    cur;
    logic [167:0]  rx_word;
    int            nbytes;
    int            busy_cnt;
    bit            prev_done;
    exp_t          e;
    pos = 0; in_char = 0; cur = '0; rx_word = '0;
    nbytes = 0; busy_cnt = 0; prev_done = 0;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        in_char = 0; pos = 0; nbytes = 0;
        rx_word = '0; busy_cnt = 0; prev_done = 0;
      end else begin
        if (!busy) chk("idle_tx", 168'(tx), 168'(1));
        if (busy) busy_cnt++;
        if (in_char) begin
          pos++;
          if (pos == 2) chk("start_bit", 168'(tx), 168'(0));
          if (pos >= 5 && pos <= 33 && (pos % 4) == 1)
            cur[(pos - 5) / 4] = tx;
          if (pos == 37) chk("stop_bit", 168'(tx), 168'(1));
          if (pos == 39) begin
            if (nbytes < NB) rx_word[8*nbytes +: 8] = cur;
            nbytes++;
            in_char = 0;
          end
        end else if (tx == 1'b0) begin
          in_char = 1;
          pos = 0;
        end
        if (done) begin
          chk("done_width", 168'(prev_done), 168'(0));
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 168'(1), 168'(0));
          end else begin
            e = exp_q.pop_front();
            chk("done_cycle", 168'(cyc), 168'(e.done_cyc));
            chk("byte_count", 168'(nbytes), 168'(NB));
            chk("packet", rx_word, 168'(e.data));
            chk("busy_len", 168'(busy_cnt), 168'(PKT));
          end
          nbytes = 0; rx_word = '0; busy_cnt = 0;
        end
        prev_done = done;
      end
    end
  end

  logic [DW-1:0] va, vb, vc;

  initial begin
    int a;
    int b;
    n_cmp = 0;
    n_fail = 0;
    rst_in = 1'b1;
    send_in = 1'b0;
    data_in = '0;
    va = {2'b10, {40{4'hA}}};
    vb = {2'b01, {20{8'h5C}}};
    vc = {2'b11, {20{8'h96}}};

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_tx", 168'(tx), 168'(1));
    chk("rst_busy", 168'(busy), 168'(0));
    chk("rst_done", 168'(done), 168'(0));
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    repeat (5) @(posedge clk_in);

    // Single packet 162'h1: check opening bit timing.
    send(162'h1, a);
    for (int i = 1; i <= 12; i++) begin
      wait_neg(a + i);
      chk("p1_tx", 168'(tx), 168'((i >= 5 && i <= 8) ? 1 : 0));
      if (i == 1) chk("p1_busy", 168'(busy), 168'(1));
    end
    wait_drain(2000);

    // All ones: last character padded to 0x03.
    send({DW{1'b1}}, a);
    wait_drain(2000);

    // Busy rejection: new request with other data mid-packet.
    send(va, a);
    wait_neg(a + 99);
    @(posedge clk_in);
    #1;
    data_in = vb;
    send_in = 1'b1;
    @(posedge clk_in);
    #1 send_in = 1'b0;
    wait_drain(2000);
    repeat (PKT + 60) @(negedge clk_in);

    // Back-to-back with send_in held high.
    @(posedge clk_in);
    #1;
    data_in = va;
    send_in = 1'b1;
    @(posedge clk_in);
    #1;
    a = cyc - 1;
    exp_q.push_back('{data: va, done_cyc: a + PKT + 1});
    data_in = vb;
    wait_neg(a + PKT);
    chk("b2b_stop", 168'(tx), 168'(1));
    wait_neg(a + PKT + 1);
    chk("b2b_gap", 168'(tx), 168'(1));
    @(posedge clk_in);
    #1 send_in = 1'b0;
    b = a + PKT + 1;
    exp_q.push_back('{data: vb, done_cyc: b + PKT + 1});
    wait_neg(a + PKT + 2);
    chk("b2b_start", 168'(tx), 168'(0));
    chk("b2b_busy", 168'(busy), 168'(1));
    wait_drain(2000);

    // Reset during DATA of character 5, then a fresh packet.
    send(vb, a);
    wait_neg(a + 214);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_tx", 168'(tx), 168'(1));
    chk("mid_rst_busy", 168'(busy), 168'(0));
    chk("mid_rst_done", 168'(done), 168'(0));
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    send(vc, a);
    wait_neg(a + 1);
    chk("rst_restart", 168'(tx), 168'(0));
    wait_drain(2000);
    repeat (20) @(negedge clk_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uar_tx.md
# uar_tx

Serial transmitter for the 162-bit packet link; the transmit-side counterpart of the `rx` path built on `uar_sampler` and `uar_fsm`. It accepts a parallel word on a one-cycle request. It then serializes the word as a burst of 8N1 UART characters, LSB first, on a single idle-high line. It sits at the board boundary, driving the wire that a remote `rx` samples.

## Interface
Parameters:
- CLKS_PER_BIT, default 868: clk_in cycles per bit period (100 MHz / 115200 baud); legal range ≥ 2.
- DATA_WIDTH, default 162: packet payload width.
- Derived localparam NUM_BYTES = ceil(DATA_WIDTH/8): 21 at the default width.

Ports:
- clk_in  input  1  system clock; all logic is on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH  packet to send; sampled only in the accept cycle.
- send_in  input  1  request strobe; honoured only while busy is low.
- tx  output  1  serial line; idle high; registered output.
- busy  output  1  high from the cycle after accept until packet end.
- done  output  1  one-cycle pulse marking packet completion.

## Operation
- Framing:
  - The packet is sent as NUM_BYTES characters.
  - Character k carries data_in[8k+7:8k].
  - The final character is zero-padded above bit DATA_WIDTH-1. At 162 bits, character 20 is {6'b0, data[161:160]}.
- Character format: start bit (0), 8 data bits LSB first, one stop bit (1).
- There is no inter-character gap. Each stop bit is followed directly by the next start bit.
- Accept: in IDLE with send_in=1, the block latches data_in, zero-padded to 8*NUM_BYTES bits, into a shift register and enters START.
  - data_in changes after the accept cycle have no effect.
- FSM states and transitions:
  - IDLE: tx=1. Waits for send_in.
  - START: tx=0 for CLKS_PER_BIT cycles, then goes to DATA with bit index 0.
  - DATA: tx = shift register bit 0. At the end of each bit period, shift right by 1 and increment the bit index. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At its end:
    - if byte index < NUM_BYTES-1, increment the byte index and go to START;
    - otherwise go to IDLE and pulse done.
- Counters:
  - baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1; clears on every state entry.
  - bit index: 3 bits.
  - byte index: $clog2(NUM_BYTES) bits.
  - Nothing wraps past its terminal value.
- send_in while busy=1 is ignored. It is neither queued nor able to corrupt the packet in flight.
- Reset at any time, including mid-character:
  - tx=1, busy=0, done=0, state IDLE, all counters and the shift register cleared;
  - the packet in flight is dropped;
  - after rst_in deasserts, the first edge may accept a request.

## Timing
- Reset values: tx=1, busy=0, done=0.
- Accept edge is cycle 0. From cycle 1:
  - busy=1;
  - tx=0 (start bit of character 0).
- Each bit is held exactly CLKS_PER_BIT cycles.
- Each character lasts 10*CLKS_PER_BIT cycles. A full packet lasts 10*NUM_BYTES*CLKS_PER_BIT cycles: 210*CLKS_PER_BIT at the default width.
- With P = packet length, in cycle P+1:
  - state is IDLE;
  - tx=1, busy=0, done=1 for exactly that one cycle.
- send_in=1 in the done cycle is accepted, giving back-to-back packets:
  - the next start bit appears one cycle later;
  - the line stays high for exactly one cycle between packets.
- send_in held high continuously produces back-to-back packets with that one-cycle idle gap.
- tx never glitches: it changes only on the rising edge of clk_in, or asynchronously to 1 on reset.

## Test plan
Run with CLKS_PER_BIT=4, DATA_WIDTH=162, so a packet is 840 cycles.
- Reset check: assert rst_in mid-simulation → tx=1, busy=0, done=0 immediately; no transitions on tx while idle.
- Single packet: data_in = 162'h1 → character 0 = 0x01, characters 1–20 = 0x00. Check:
  - start bit in cycle 1;
  - tx low for 4 cycles, then LSB=1 for 4 cycles;
  - done in cycle 841, busy high in cycles 1–840.
- Padding and ordering: data_in = all ones → characters 0–19 = 0xFF, character 20 = 0x03. A reference UART decoder on tx recovers the 21 bytes; feeding the wire into `rx` yields data_out = all ones with ready asserted.
- Busy rejection: with data A = 162'h2AAAA…, pulse send_in with data B at cycle 100 → wire still carries A unchanged; exactly one done pulse.
- Back-to-back: hold send_in high with data A then B → second start bit at cycle 842; the line is high only in cycle 841 between packets; two done pulses, 841 cycles apart.
- Reset mid-packet: assert rst_in during the DATA state of character 5 → tx=1 within the reset, busy=0, no done pulse. A new send_in after release restarts from character 0 with the new data.
